// File: rtl/mch_dec_s2p_top.sv
// Manchester receiver: recovers bit timing from rxsdi, checks the sync word and
// delivers a fixed-length frame one byte at a time together with its index.
module mch_dec_s2p_top #(
  parameter int         CLK_PER_BIT = 16,
  parameter logic [7:0] SYNC_WORD   = 8'h2D,
  parameter int         N_BYTES     = 7,
  parameter int         IDLE_BITS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxsdi,
  output logic [7:0] rx_data,
  output logic [2:0] rx_idx,
  output logic       rx_valid,
  output logic       rx_done,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int PH_W = $clog2(5*CLK_PER_BIT/4 + 2);
  localparam int IC_W = $clog2(IDLE_BITS*CLK_PER_BIT + 1);
  localparam logic [PH_W-1:0] PH_LO    = PH_W'(3*CLK_PER_BIT/4);
  localparam logic [PH_W-1:0] PH_HI    = PH_W'(5*CLK_PER_BIT/4);
  localparam logic [IC_W-1:0] IDLE_LIM = IC_W'(IDLE_BITS*CLK_PER_BIT);
  localparam logic [2:0]      LAST_IDX = 3'(N_BYTES-1);
  localparam logic [1:0]      ERR_SYNC = 2'd1;
  localparam logic [1:0]      ERR_MID  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SYNC, S_DATA} state_t;

  state_t          state;
  logic [IC_W-1:0] idle_cnt;
  logic [PH_W-1:0] ph;
  logic [2:0]      bit_cnt;
  logic [2:0]      byte_idx;
  logic [7:0]      shreg_p0;
  logic            vld_p0;
  logic            rxsdi_p0, rxsdi_p1, rxsdi_p2;
  logic            edge_p2;
  logic            mid_ok;

  // Stage p0/p1: two-flop synchronizer; stage p2: previous level for edge detection
  always_ff @(posedge clk) begin
    rxsdi_p0 <= rxsdi;
    rxsdi_p1 <= rxsdi_p0;
    rxsdi_p2 <= rxsdi_p1;
  end

  assign edge_p2 = rxsdi_p1 ^ rxsdi_p2;
  assign mid_ok  = edge_p2 && (ph >= PH_LO) && (ph <= PH_HI);

  // Bit/byte stage: shreg_p0 collects bits, vld_p0 marks a full byte for the next cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      idle_cnt <= '0;
      ph       <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg_p0 <= '0;
      vld_p0   <= 1'b0;
      rx_data  <= '0;
      rx_idx   <= '0;
      rx_valid <= 1'b0;
      rx_done  <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= '0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_done  <= 1'b0;
      rx_err   <= 1'b0;
      vld_p0   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxsdi_p1)
            idle_cnt <= '0;
          else if (idle_cnt == IDLE_LIM)
            state <= S_ARMED;
          else
            idle_cnt <= idle_cnt + 1'b1;
        end
        S_ARMED: begin
          // first falling edge is the mid-bit of the leading sync zero
          if (edge_p2 && !rxsdi_p1) begin
            shreg_p0 <= {shreg_p0[6:0], 1'b0};
            bit_cnt  <= 3'd1;
            ph       <= '0;
            busy     <= 1'b1;
            idle_cnt <= '0;
            state    <= S_SYNC;
          end
        end
        S_SYNC, S_DATA: begin
          ph <= ph + 1'b1;
          if (vld_p0) begin
            if (state == S_SYNC) begin
              if (shreg_p0 == SYNC_WORD) begin
                byte_idx <= '0;
                state    <= S_DATA;
              end else begin
                rx_err   <= 1'b1;
                err_code <= ERR_SYNC;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end
            end else begin
              rx_data  <= shreg_p0;
              rx_idx   <= byte_idx;
              rx_valid <= 1'b1;
              byte_idx <= byte_idx + 1'b1;
              if (byte_idx == LAST_IDX) begin
                rx_done <= 1'b1;
                busy    <= 1'b0;
                state   <= S_IDLE;
              end
            end
          end else if (mid_ok) begin
            shreg_p0 <= {shreg_p0[6:0], rxsdi_p1};
            ph       <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            vld_p0   <= (bit_cnt == 3'd7);
          end else if (ph == PH_HI) begin
            rx_err   <= 1'b1;
            err_code <= ERR_MID;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mch_dec_s2p_top.sv
// Bench for mch_dec_s2p_top: builds a line waveform from frame descriptions and
// predicts every output per cycle from the positions of the mid-bit transitions.
module tb_mch_dec_s2p_top;
  localparam int CPB  = 16;
  localparam int MAXC = 16384;
  localparam logic [7:0] SYNC = 8'h2D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxsdi = 1'b1;
  logic [7:0] rx_data;
  logic [2:0] rx_idx;
  logic       rx_valid, rx_done, rx_err, busy;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  mch_dec_s2p_top #(.CLK_PER_BIT(CPB), .SYNC_WORD(SYNC), .N_BYTES(7), .IDLE_BITS(2)) dut (
    .clk(clk), .rst(rst), .rxsdi(rxsdi), .rx_data(rx_data), .rx_idx(rx_idx),
    .rx_valid(rx_valid), .rx_done(rx_done), .rx_err(rx_err), .err_code(err_code), .busy(busy)
  );

  logic       line_a [MAXC];
  logic       rst_a  [MAXC];
  logic       e_valid[MAXC];
  logic       e_done [MAXC];
  logic       e_err  [MAXC];
  logic       e_busy [MAXC];
  logic [7:0] e_dat  [MAXC];
  logic [2:0] e_ix   [MAXC];
  logic [1:0] e_cd   [MAXC];
  logic [7:0] ex_data[MAXC];
  logic [2:0] ex_idx [MAXC];
  logic [1:0] ex_code[MAXC];
  logic [7:0] fbytes [7];
  int len;
  int rst_cyc = -10;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic put(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (len < MAXC) begin
        line_a[len] = v;
        rst_a[len]  = 1'b1;
        len++;
      end
    end
  endtask

  // Appends one frame; cut = bit whose mid transition goes missing, stop = bit at which rst pulses.
  task automatic send_frame(input logic [7:0] sw, input int idle, input bit decode,
                            input bit jit, input int cut, input int stop);
    int mids[64];
    int nfull, r, endb, h2, k8;
    logic b;
    nfull = 64; r = -1; endb = -1;
    put(1'b1, idle);
    for (int k = 0; k < 64; k++) begin
      if (k < 8) b = sw[7-k];
      else begin
        k8 = k - 8;
        b = fbytes[k8/8][7-(k8%8)];
      end
      h2 = jit ? ((k % 2 == 0) ? CPB/2 + 3 : CPB/2 - 3) : CPB/2;
      if (k == stop) begin
        r = len;
        put(1'b0, 20);
        rst_a[r] = 1'b0;
        rst_cyc = r;
        nfull = k;
        break;
      end
      if (k == cut) begin
        put(~b, CPB/2 + 40);
        nfull = k;
        break;
      end
      put(~b, CPB/2);
      mids[k] = len;
      put(b, h2);
    end
    if (decode) begin
      if (sw != SYNC) begin
        e_err[mids[7]+4] = 1'b1; e_cd[mids[7]+4] = 2'd1;
        endb = mids[7] + 3;
      end else begin
        for (int j = 0; j < 7; j++) begin
          if (8 + 8*j + 7 < nfull) begin
            e_valid[mids[15+8*j]+4] = 1'b1;
            e_dat[mids[15+8*j]+4]   = fbytes[j];
            e_ix[mids[15+8*j]+4]    = 3'(j);
            if (j == 6) e_done[mids[15+8*j]+4] = 1'b1;
            endb = mids[15+8*j] + 3;
          end
        end
        if (cut >= 0 && nfull == cut) begin
          e_err[mids[nfull-1]+24] = 1'b1; e_cd[mids[nfull-1]+24] = 2'd2;
          endb = mids[nfull-1] + 23;
        end
        if (r >= 0) endb = r;
      end
      for (int n = mids[0] + 3; n <= endb; n++) e_busy[n] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int n, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h, expected %h (vld,done,err,busy|data|idx|code)", nm, n, act, exp);
    end
  endtask

  initial begin
    logic [7:0] hd;
    logic [2:0] hi;
    logic [1:0] hc;
    for (int i = 0; i < MAXC; i++) begin
      line_a[i] = 1'b1; rst_a[i] = 1'b1;
      e_valid[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0; e_busy[i] = 1'b0;
      e_dat[i] = '0; e_ix[i] = '0; e_cd[i] = '0;
    end
    fbytes = '{8'h01, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5A};
    len = 0;
    put(1'b1, 4);
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;
    send_frame(SYNC,  48, 1, 0, -1, -1);  // nominal after 3 us idle
    send_frame(SYNC,  32, 1, 1, -1, -1);  // alternating +/-3 clk mid-bit jitter
    send_frame(8'h2C, 32, 1, 0, -1, -1);  // sync mismatch
    send_frame(SYNC,  32, 1, 0, -1, -1);
    send_frame(SYNC,  32, 1, 0, 27, -1);  // byte 2 bit 4 never transitions
    send_frame(SYNC,  32, 1, 0, -1, -1);
    send_frame(SYNC,  32, 1, 0, -1, 35);  // reset pulse during byte 3
    send_frame(SYNC,  16, 0, 0, -1, -1);  // only 1 us idle: ignored
    send_frame(SYNC,  32, 1, 0, -1, -1);
    send_frame(SYNC,  24, 0, 0, -1, -1);  // 1.5 us gap: ignored
    send_frame(SYNC,  32, 1, 0, -1, -1);
    put(1'b1, 40);

    hd = '0; hi = '0; hc = '0;
    for (int n = 0; n < len + 8; n++) begin
      if (n >= 1 && n - 1 < len && !rst_a[n-1]) begin hd = '0; hi = '0; hc = '0; end
      if (e_valid[n]) begin hd = e_dat[n]; hi = e_ix[n]; end
      if (e_err[n]) hc = e_cd[n];
      ex_data[n] = hd; ex_idx[n] = hi; ex_code[n] = hc;
    end

    fork
      begin
        for (int n = 0; n < len + 8; n++) begin
          @(negedge clk);
          rst   = (n < len) ? rst_a[n]  : 1'b1;
          rxsdi = (n < len) ? line_a[n] : 1'b1;
        end
      end
      begin
        for (int n = 0; n < len + 8; n++) begin
          @(negedge clk);
          if (n >= 1) begin
            chk("cycle", n,
                {3'b0, rx_valid, rx_done, rx_err, busy, rx_data, rx_idx, err_code},
                {3'b0, e_valid[n], e_done[n], e_err[n], e_busy[n], ex_data[n], ex_idx[n], ex_code[n]});
            if (n == 2)
              chk("reset_state", n, {3'b0, rx_valid, rx_done, rx_err, busy, rx_data, rx_idx, err_code}, 20'h0);
            if (n == 62) chk("busy_before_first_edge", n, {19'b0, busy}, 20'h0);
            if (n == 63) chk("busy_after_first_edge", n, {19'b0, busy}, 20'h1);
            if (n == 304)
              chk("first_byte", n, {8'b0, rx_valid, rx_idx, rx_data}, {8'b0, 1'b1, 3'd0, 8'h01});
            if (n == 432)
              chk("second_byte", n, {8'b0, rx_valid, rx_idx, rx_data}, {8'b0, 1'b1, 3'd1, 8'h04});
            if (n == 1072)
              chk("last_byte_done", n, {7'b0, rx_valid, rx_done, rx_idx, rx_data},
                  {7'b0, 1'b1, 1'b1, 3'd6, 8'h5A});
            if (n == rst_cyc + 1)
              chk("reset_abort", n, {3'b0, rx_valid, rx_done, rx_err, busy, rx_data, rx_idx, err_code}, 20'h0);
          end
        end
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
